// File: rtl/kpn_adder_node.sv
// kpn_adder_node: KPN process node between FIFO stages. It pops one token from each of two
// upstream FIFOs (A, B), adds them and pushes the sum into one downstream FIFO. It uses Kahn
// blocking-read / blocking-write semantics: it never pops an empty FIFO and never pushes a full one.
//
// Build option: define KPN_ADDER_SATURATE_EN to clamp a sum that carries out to all ones.
// Without it, the low BITS_NUMBER bits are written (modular wrap). In both builds a carry sets
// o_overflow.
//
// Ports:
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_empty_a, i_data_a   FIFO A empty flag and registered output
//   o_rd_a                FIFO A read strobe (one-cycle pulse)
//   i_empty_b, i_data_b   FIFO B empty flag and registered output
//   o_rd_b                FIFO B read strobe (one-cycle pulse)
//   i_full_out            downstream FIFO full flag
//   o_wr_out, o_data_out  downstream write strobe (one-cycle pulse) and write data
//   o_busy                high whenever the FSM is not idle
//   o_token_count         number of sums written since reset (wraps)
//   o_overflow            sticky: some addition produced a carry out
module kpn_adder_node #(
  parameter int unsigned BITS_NUMBER = 16,
  parameter int unsigned COUNT_BITS  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_empty_a,
  input  logic [BITS_NUMBER-1:0] i_data_a,
  output logic                   o_rd_a,
  input  logic                   i_empty_b,
  input  logic [BITS_NUMBER-1:0] i_data_b,
  output logic                   o_rd_b,
  input  logic                   i_full_out,
  output logic                   o_wr_out,
  output logic [BITS_NUMBER-1:0] o_data_out,
  output logic                   o_busy,
  output logic [COUNT_BITS-1:0]  o_token_count,
  output logic                   o_overflow
);

  typedef enum logic [1:0] {StIdle, StPop, StLatch, StPush} state_e;

  state_e r_state;
  state_e w_state_next;

  logic                   r_rd;
  logic                   r_wr;
  logic                   r_busy;
  logic [BITS_NUMBER-1:0] r_data_out;
  logic [COUNT_BITS-1:0]  r_token_count;
  logic                   r_overflow;

  logic                   w_rd_next;
  logic                   w_wr_next;
  logic                   w_busy_next;
  logic [BITS_NUMBER-1:0] w_data_out_next;
  logic [COUNT_BITS-1:0]  w_token_count_next;
  logic                   w_overflow_next;

  logic [BITS_NUMBER:0]   w_sum;
  logic                   w_carry;
  logic [BITS_NUMBER-1:0] w_result;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!i_empty_a && !i_empty_b && !i_full_out) begin
          w_state_next = StPop;
        end
      end
      StPop:   w_state_next = StLatch;
      StLatch: w_state_next = StPush;
      StPush:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Unsigned add with one extra bit for the carry. The FIFO outputs are valid in the LATCH cycle
  // because the read pulse in POP updated them at its closing edge.
  assign w_sum   = {1'b0, i_data_a} + {1'b0, i_data_b};
  assign w_carry = w_sum[BITS_NUMBER];

`ifdef KPN_ADDER_SATURATE_EN
  assign w_result = w_carry ? {BITS_NUMBER{1'b1}} : w_sum[BITS_NUMBER-1:0];
`else
  assign w_result = w_sum[BITS_NUMBER-1:0];
`endif

  // Output logic: outputs are decoded from the next state so every output is a register. The
  // LATCH -> PUSH edge loads the sum, count and overflow, so they are valid with the wr_out pulse.
  always_comb begin
    w_rd_next          = (w_state_next == StPop);
    w_wr_next          = (w_state_next == StPush);
    w_busy_next        = (w_state_next != StIdle);
    w_data_out_next    = r_data_out;
    w_token_count_next = r_token_count;
    w_overflow_next    = r_overflow;
    if (r_state == StLatch) begin
      w_data_out_next    = w_result;
      w_token_count_next = r_token_count + COUNT_BITS'(1);
      w_overflow_next    = r_overflow | w_carry;
    end
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd          <= 1'b0;
      r_wr          <= 1'b0;
      r_busy        <= 1'b0;
      r_data_out    <= '0;
      r_token_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_rd          <= w_rd_next;
      r_wr          <= w_wr_next;
      r_busy        <= w_busy_next;
      r_data_out    <= w_data_out_next;
      r_token_count <= w_token_count_next;
      r_overflow    <= w_overflow_next;
    end
  end

  // A single read strobe drives both FIFOs, so they are always popped together.
  assign o_rd_a        = r_rd;
  assign o_rd_b        = r_rd;
  assign o_wr_out      = r_wr;
  assign o_busy        = r_busy;
  assign o_data_out    = r_data_out;
  assign o_token_count = r_token_count;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_kpn_adder_node.sv
module tb_kpn_adder_node;

  localparam int unsigned BITS_NUMBER = 16;
  localparam int unsigned COUNT_BITS  = 16;

  logic                   clk;
  logic                   reset;
  logic                   empty_a;
  logic [BITS_NUMBER-1:0] data_a;
  logic                   rd_a;
  logic                   empty_b;
  logic [BITS_NUMBER-1:0] data_b;
  logic                   rd_b;
  logic                   full_out;
  logic                   wr_out;
  logic [BITS_NUMBER-1:0] data_out;
  logic                   busy;
  logic [COUNT_BITS-1:0]  token_count;
  logic                   overflow;

  kpn_adder_node #(
    .BITS_NUMBER(BITS_NUMBER),
    .COUNT_BITS (COUNT_BITS)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_empty_a    (empty_a),
    .i_data_a     (data_a),
    .o_rd_a       (rd_a),
    .i_empty_b    (empty_b),
    .i_data_b     (data_b),
    .o_rd_b       (rd_b),
    .i_full_out   (full_out),
    .o_wr_out     (wr_out),
    .o_data_out   (data_out),
    .o_busy       (busy),
    .o_token_count(token_count),
    .o_overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Upstream FIFO models with registered read port. Stimulus owns the write pointers, the
  // posedge process owns the read pointers.
  logic [BITS_NUMBER-1:0] mem_a [64];
  logic [BITS_NUMBER-1:0] mem_b [64];
  int wp_a = 0, wp_b = 0, rp_a = 0, rp_b = 0;

  assign empty_a = (wp_a == rp_a);
  assign empty_b = (wp_b == rp_b);

  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_a && !empty_a) begin
      data_a <= mem_a[rp_a];
      rp_a   <= rp_a + 1;
    end
    if (rd_b && !empty_b) begin
      data_b <= mem_b[rp_b];
      rp_b   <= rp_b + 1;
    end
  end

  // Scoreboard: expected {data_out, token_count, overflow} per write
  typedef struct {
    logic [BITS_NUMBER-1:0] data;
    logic [COUNT_BITS-1:0]  count;
    logic                   ovf;
  } exp_t;
  exp_t exp_q[$];

  int rd_pulses = 0;
  int wr_pulses = 0;
  int last_rd_cyc = 0;

  // Monitor samples on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_a || rd_b) begin
        rd_pulses++;
        last_rd_cyc = cyc;
        check("rd_a_eq_rd_b", {31'd0, rd_a}, {31'd0, rd_b});
        check("pop_not_empty", {31'd0, empty_a | empty_b}, 32'd0);
      end
      if (wr_out) begin
        exp_t e;
        wr_pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: data_out 0x%0h, no write expected", data_out);
        end else begin
          e = exp_q.pop_front();
          check("data_out", {16'd0, data_out}, {16'd0, e.data});
          check("token_count", {16'd0, token_count}, {16'd0, e.count});
          check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
          check("rd_to_wr_latency", cyc - last_rd_cyc, 32'd2);
        end
      end
    end
  end

  task automatic push_a(input logic [BITS_NUMBER-1:0] v);
    mem_a[wp_a] = v;
    wp_a++;
  endtask

  task automatic push_b(input logic [BITS_NUMBER-1:0] v);
    mem_b[wp_b] = v;
    wp_b++;
  endtask

  task automatic expect_sum(input logic [BITS_NUMBER-1:0] d, input logic [COUNT_BITS-1:0] c,
                            input logic o);
    exp_t e;
    e.data  = d;
    e.count = c;
    e.ovf   = o;
    exp_q.push_back(e);
  endtask

  // Bounded wait for all expected writes and an idle DUT
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain_%s: %0d writes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int rd_before;
    int wr_before;
    logic [BITS_NUMBER-1:0] sat_exp;

    reset    = 1'b1;
    full_out = 1'b0;
    data_a   = '0;
    data_b   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_rd_a", {31'd0, rd_a}, 32'd0);
    check("rst_rd_b", {31'd0, rd_b}, 32'd0);
    check("rst_wr_out", {31'd0, wr_out}, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_token_count", {16'd0, token_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // All FIFOs empty: no pulses for 20 clk
    repeat (20) @(negedge clk);
    check("idle_rd_pulses", rd_pulses, 32'd0);
    check("idle_wr_pulses", wr_pulses, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 3 + 5 = 8
    expect_sum(16'd8, 16'd1, 1'b0);
    push_a(16'd3);
    push_b(16'd5);
    drain("basic");

    // 0xFFFF + 0x0002 carries out
`ifdef KPN_ADDER_SATURATE_EN
    sat_exp = 16'hFFFF;
`else
    sat_exp = 16'h0001;
`endif
    expect_sum(sat_exp, 16'd2, 1'b1);
    push_a(16'hFFFF);
    push_b(16'h0002);
    drain("carry");

    // A has 4 tokens, B empty: nothing must be popped
    rd_before = rd_pulses;
    push_a(16'd10);
    push_a(16'd20);
    push_a(16'd30);
    push_a(16'd40);
    repeat (20) @(negedge clk);
    check("a_only_no_rd", rd_pulses - rd_before, 32'd0);
    check("a_only_not_busy", {31'd0, busy}, 32'd0);

    // Supply B: four sums in FIFO order; overflow stays sticky
    wr_before = wr_pulses;
    expect_sum(16'd11, 16'd3, 1'b1);
    expect_sum(16'd22, 16'd4, 1'b1);
    expect_sum(16'd33, 16'd5, 1'b1);
    expect_sum(16'd44, 16'd6, 1'b1);
    push_b(16'd1);
    push_b(16'd2);
    push_b(16'd3);
    push_b(16'd4);
    drain("four");
    check("four_wr_count", wr_pulses - wr_before, 32'd4);

    // Downstream full: no transfer until it clears
    full_out = 1'b1;
    rd_before = rd_pulses;
    push_a(16'd7);
    push_b(16'd9);
    repeat (10) @(negedge clk);
    check("full_no_rd", rd_pulses - rd_before, 32'd0);
    check("full_no_busy", {31'd0, busy}, 32'd0);
    expect_sum(16'd16, 16'd7, 1'b1);
    full_out = 1'b0;
    @(negedge clk);
    check("unfull_rd_next_clk", {31'd0, rd_a}, 32'd1);
    drain("unfull");

    // Reset asserted in LATCH abandons the token
    wr_before = wr_pulses;
    push_a(16'd1);
    push_b(16'd1);
    begin
      int n;
      n = 0;
      while (!rd_a && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("latch_test_rd_seen", {31'd0, rd_a}, 32'd1);
    end
    @(negedge clk); // DUT now in LATCH
    check("latch_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("latch_rst_busy", {31'd0, busy}, 32'd0);
    check("latch_rst_wr", {31'd0, wr_out}, 32'd0);
    check("latch_rst_count", {16'd0, token_count}, 32'd0);
    check("latch_rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("latch_no_write", wr_pulses - wr_before, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
